// File: rtl/decode_execute_reg.sv
// Decode-to-execute pipeline register with hazard-unit hold and bubble insertion.
// Latency: 1 cycle from D inputs to E outputs; outputs driven straight from flops.
// Backpressure: StallE holds contents and counter; FlushE loads a bubble and wins over StallE.
module decode_execute_reg #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      StallE,
   input  logic                      FlushE,
   input  logic                      ValidD,
   input  logic                      RegWriteD,
   input  logic [1:0]                ResultSrcD,
   input  logic                      MemWriteD,
   input  logic                      JumpD,
   input  logic                      BranchD,
   input  logic [2:0]                ALUControlD,
   input  logic                      ALUSrcAD,
   input  logic                      ALUSrcBD,
   input  logic                      LdSrcD,
   input  logic                      StSrcD,
   input  logic                      JalSrcD,
   input  logic [2:0]                Funct3D,
   input  logic [DATA_WIDTH-1:0]     RD1D,
   input  logic [DATA_WIDTH-1:0]     RD2D,
   input  logic [DATA_WIDTH-1:0]     PCD,
   input  logic [DATA_WIDTH-1:0]     PCPlus4D,
   input  logic [DATA_WIDTH-1:0]     ImmExtD,
   input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
   input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
   input  logic [REG_ADDR_WIDTH-1:0] RdD,
   output logic                      ValidE,
   output logic                      RegWriteE,
   output logic [1:0]                ResultSrcE,
   output logic                      MemWriteE,
   output logic                      JumpE,
   output logic                      BranchE,
   output logic [2:0]                ALUControlE,
   output logic                      ALUSrcAE,
   output logic                      ALUSrcBE,
   output logic                      LdSrcE,
   output logic                      StSrcE,
   output logic                      JalSrcE,
   output logic [2:0]                Funct3E,
   output logic [DATA_WIDTH-1:0]     RD1E,
   output logic [DATA_WIDTH-1:0]     RD2E,
   output logic [DATA_WIDTH-1:0]     PCE,
   output logic [DATA_WIDTH-1:0]     PCPlus4E,
   output logic [DATA_WIDTH-1:0]     ImmExtE,
   output logic [REG_ADDR_WIDTH-1:0] Rs1E,
   output logic [REG_ADDR_WIDTH-1:0] Rs2E,
   output logic [REG_ADDR_WIDTH-1:0] RdE,
   output logic [CNT_WIDTH-1:0]      BubbleCount
);

   // All stage fields travel together so reset and bubble clear them in one assignment.
   typedef struct packed {
      logic                      valid;
      logic                      regWrite;
      logic [1:0]                resultSrc;
      logic                      memWrite;
      logic                      jump;
      logic                      branch;
      logic [2:0]                aluControl;
      logic                      aluSrcA;
      logic                      aluSrcB;
      logic                      ldSrc;
      logic                      stSrc;
      logic                      jalSrc;
      logic [2:0]                funct3;
      logic [DATA_WIDTH-1:0]     rd1;
      logic [DATA_WIDTH-1:0]     rd2;
      logic [DATA_WIDTH-1:0]     pc;
      logic [DATA_WIDTH-1:0]     pcPlus4;
      logic [DATA_WIDTH-1:0]     immExt;
      logic [REG_ADDR_WIDTH-1:0] rs1;
      logic [REG_ADDR_WIDTH-1:0] rs2;
      logic [REG_ADDR_WIDTH-1:0] rd;
   } stageFields_t;

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

   stageFields_t decodeFields;
   stageFields_t execFields;

   // Gather the decode-stage inputs into one bundle.
   always_comb begin
      decodeFields            = '0;
      decodeFields.valid      = ValidD;
      decodeFields.regWrite   = RegWriteD;
      decodeFields.resultSrc  = ResultSrcD;
      decodeFields.memWrite   = MemWriteD;
      decodeFields.jump       = JumpD;
      decodeFields.branch     = BranchD;
      decodeFields.aluControl = ALUControlD;
      decodeFields.aluSrcA    = ALUSrcAD;
      decodeFields.aluSrcB    = ALUSrcBD;
      decodeFields.ldSrc      = LdSrcD;
      decodeFields.stSrc      = StSrcD;
      decodeFields.jalSrc     = JalSrcD;
      decodeFields.funct3     = Funct3D;
      decodeFields.rd1        = RD1D;
      decodeFields.rd2        = RD2D;
      decodeFields.pc         = PCD;
      decodeFields.pcPlus4    = PCPlus4D;
      decodeFields.immExt     = ImmExtD;
      decodeFields.rs1        = Rs1D;
      decodeFields.rs2        = Rs2D;
      decodeFields.rd         = RdD;
   end

   // Stage register: reset beats flush beats stall beats capture. A bubble zeroes
   // the index fields too so RdE can never produce a false forwarding match.
   always_ff @(posedge clk) begin
      if (rst) begin
         execFields  <= '0;
         BubbleCount <= '0;
      end else if (FlushE) begin
         execFields <= '0;
         if (BubbleCount != CNT_MAX) begin
            BubbleCount <= BubbleCount + CNT_ONE;
         end
      end else if (!StallE) begin
         execFields <= decodeFields;
      end
   end

   assign ValidE      = execFields.valid;
   assign RegWriteE   = execFields.regWrite;
   assign ResultSrcE  = execFields.resultSrc;
   assign MemWriteE   = execFields.memWrite;
   assign JumpE       = execFields.jump;
   assign BranchE     = execFields.branch;
   assign ALUControlE = execFields.aluControl;
   assign ALUSrcAE    = execFields.aluSrcA;
   assign ALUSrcBE    = execFields.aluSrcB;
   assign LdSrcE      = execFields.ldSrc;
   assign StSrcE      = execFields.stSrc;
   assign JalSrcE     = execFields.jalSrc;
   assign Funct3E     = execFields.funct3;
   assign RD1E        = execFields.rd1;
   assign RD2E        = execFields.rd2;
   assign PCE         = execFields.pc;
   assign PCPlus4E    = execFields.pcPlus4;
   assign ImmExtE     = execFields.immExt;
   assign Rs1E        = execFields.rs1;
   assign Rs2E        = execFields.rs2;
   assign RdE         = execFields.rd;

endmodule

// File: tb/tb_decode_execute_reg.sv
// Directed bench for the decode-to-execute register, built with a 4-bit bubble counter.
// Latency: checks sample 1 time unit after each rising edge.
// Backpressure: exercises stall hold, flush bubble, flush-over-stall and counter saturation.
module tb_decode_execute_reg;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int CW = 4;
   localparam int VW = 193;

   logic clk = 1'b0;
   logic rst, StallE, FlushE;
   logic ValidD, RegWriteD, MemWriteD, JumpD, BranchD;
   logic ALUSrcAD, ALUSrcBD, LdSrcD, StSrcD, JalSrcD;
   logic [1:0] ResultSrcD;
   logic [2:0] ALUControlD, Funct3D;
   logic [DW-1:0] RD1D, RD2D, PCD, PCPlus4D, ImmExtD;
   logic [AW-1:0] Rs1D, Rs2D, RdD;
   logic ValidE, RegWriteE, MemWriteE, JumpE, BranchE;
   logic ALUSrcAE, ALUSrcBE, LdSrcE, StSrcE, JalSrcE;
   logic [1:0] ResultSrcE;
   logic [2:0] ALUControlE, Funct3E;
   logic [DW-1:0] RD1E, RD2E, PCE, PCPlus4E, ImmExtE;
   logic [AW-1:0] Rs1E, Rs2E, RdE;
   logic [CW-1:0] BubbleCount;

   int checks = 0;
   int errors = 0;

   logic [VW-1:0] allE;
   logic [VW-1:0] patA, patB, expV;

   always #5 clk = ~clk;

   decode_execute_reg #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst), .StallE(StallE), .FlushE(FlushE),
      .ValidD(ValidD), .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD),
      .MemWriteD(MemWriteD), .JumpD(JumpD), .BranchD(BranchD),
      .ALUControlD(ALUControlD), .ALUSrcAD(ALUSrcAD), .ALUSrcBD(ALUSrcBD),
      .LdSrcD(LdSrcD), .StSrcD(StSrcD), .JalSrcD(JalSrcD), .Funct3D(Funct3D),
      .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .PCPlus4D(PCPlus4D), .ImmExtD(ImmExtD),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
      .ValidE(ValidE), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE),
      .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
      .ALUControlE(ALUControlE), .ALUSrcAE(ALUSrcAE), .ALUSrcBE(ALUSrcBE),
      .LdSrcE(LdSrcE), .StSrcE(StSrcE), .JalSrcE(JalSrcE), .Funct3E(Funct3E),
      .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .PCPlus4E(PCPlus4E), .ImmExtE(ImmExtE),
      .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .BubbleCount(BubbleCount)
   );

   // Flattened view of every E output, in the same field order used by driveD.
   assign allE = {ValidE, RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE,
                  ALUSrcAE, ALUSrcBE, LdSrcE, StSrcE, JalSrcE, Funct3E,
                  RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE};

   task automatic driveD(input logic [VW-1:0] v);
      {ValidD, RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD, ALUControlD,
       ALUSrcAD, ALUSrcBD, LdSrcD, StSrcD, JalSrcD, Funct3D,
       RD1D, RD2D, PCD, PCPlus4D, ImmExtD, Rs1D, Rs2D, RdD} = v;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      patA = {1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 3'b010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'b101,
              32'h1111_2222, 32'h3333_4444, 32'h0000_0100, 32'h0000_0104, 32'hFFFF_FFF0,
              5'd1, 5'd2, 5'd3};
      patB = {1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0, 3'b110, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b011,
              32'hAAAA_5555, 32'h0BAD_F00D, 32'h0000_0200, 32'h0000_0204, 32'h0000_0010,
              5'd11, 5'd12, 5'd13};

      // Reset with every D input at ones.
      rst = 1'b1; StallE = 1'b0; FlushE = 1'b0;
      driveD({VW{1'b1}});
      step();
      step();
      check("reset_outputs", allE, '0);
      check("reset_count", BubbleCount, 4'd0);

      // First capture after reset release.
      rst = 1'b0;
      step();
      check("post_reset_capture", allE, {VW{1'b1}});

      // Pass-through: outputs must not move before the edge, then follow after one edge.
      driveD('0);
      RegWriteD = 1'b1; ALUControlD = 3'b001; RD1D = 32'h0000_1234; RdD = 5'd5; ValidD = 1'b1;
      #2;
      check("no_comb_path", allE, {VW{1'b1}});
      step();
      check("pass_regwrite", RegWriteE, 1'b1);
      check("pass_aluctl", ALUControlE, 3'b001);
      check("pass_rd1", RD1E, 32'h0000_1234);
      check("pass_rd", RdE, 5'd5);
      check("pass_valid", ValidE, 1'b1);
      expV = {1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 3'b001, 5'b0, 3'b000,
              32'h0000_1234, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd5};
      check("pass_all", allE, expV);

      // Stall: A held for three cycles while B sits on the D inputs.
      driveD(patA);
      step();
      check("load_A", allE, patA);
      StallE = 1'b1;
      driveD(patB);
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall_hold", allE, patA);
      end
      check("stall_count", BubbleCount, 4'd0);
      StallE = 1'b0;
      step();
      check("stall_release_B", allE, patB);

      // Flush of a branch with RdE=7.
      driveD('0);
      BranchD = 1'b1; RdD = 5'd7; ValidD = 1'b1; Funct3D = 3'b001; Rs1D = 5'd4;
      step();
      check("branch_rd", RdE, 5'd7);
      check("branch_bit", BranchE, 1'b1);
      FlushE = 1'b1;
      driveD(patA);
      step();
      check("flush_outputs", allE, '0);
      check("flush_count", BubbleCount, 4'd1);
      FlushE = 1'b0;
      step();
      check("after_flush_capture", allE, patA);

      // Flush and stall together: bubble, not a hold.
      FlushE = 1'b1; StallE = 1'b1;
      driveD(patB);
      step();
      check("flush_stall_outputs", allE, '0);
      check("flush_stall_count", BubbleCount, 4'd2);

      // Stall alone keeps the bubble and the count.
      FlushE = 1'b0;
      step();
      check("stall_after_flush", allE, '0);
      check("stall_count_hold", BubbleCount, 4'd2);
      StallE = 1'b0;

      // Saturation: 20 more flushes, count tops out at 15.
      FlushE = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         logic [CW-1:0] expCnt;
         expCnt = ((2 + i) > 15) ? 4'd15 : 4'(2 + i);
         step();
         check("sat_count", BubbleCount, expCnt);
      end
      FlushE = 1'b0;

      // Mid-stream reset discards the in-flight instruction and clears the counter.
      driveD(patA);
      step();
      check("reload_A", allE, patA);
      rst = 1'b1;
      driveD(patB);
      step();
      check("midreset_outputs", allE, '0);
      check("midreset_count", BubbleCount, 4'd0);
      rst = 1'b0;

      // Invalid slot still carries its control bits unmasked.
      driveD('0);
      ValidD = 1'b0; RegWriteD = 1'b1; MemWriteD = 1'b1; RdD = 5'd9;
      step();
      check("invalid_valid", ValidE, 1'b0);
      check("invalid_regwrite", RegWriteE, 1'b1);
      check("invalid_memwrite", MemWriteE, 1'b1);
      check("invalid_rd", RdE, 5'd9);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/decode_execute_reg.md
Name: decode_execute_reg

Overview:
- Decode-to-execute (D→E) pipeline register of the 5-stage RV32I core.
- Sits directly downstream of the decode-stage control unit and register file, and upstream of the execute-stage ALU, forwarding muxes and branch logic.
- Captures all decode-stage control and data fields each cycle.
- Supports hazard-unit stall (hold) and flush (bubble insertion).
- Keeps a saturating bubble counter for performance monitoring.

Parameters:
- DATA_WIDTH, 32, width of register operands, PC, PC+4 and immediate.
- REG_ADDR_WIDTH, 5, width of register-file indices.
- CNT_WIDTH, 16, width of the bubble counter.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- StallE  input  1  hold current contents (from hazard unit)
- FlushE  input  1  load a bubble (from hazard unit)
- ValidD  input  1  decode slot holds a real instruction
- RegWriteD  input  1  register write enable
- ResultSrcD  input  2  writeback result select
- MemWriteD  input  1  data memory write enable
- JumpD  input  1  jump instruction
- BranchD  input  1  branch instruction
- ALUControlD  input  3  ALU operation
- ALUSrcAD  input  1  ALU A operand select (PC vs rs1)
- ALUSrcBD  input  1  ALU B operand select (imm vs rs2)
- LdSrcD  input  1  load width select
- StSrcD  input  1  store width select
- JalSrcD  input  1  PC-relative target select
- Funct3D  input  3  funct3 for branch-condition evaluation
- RD1D, RD2D  input  DATA_WIDTH each  register-file read data
- PCD, PCPlus4D, ImmExtD  input  DATA_WIDTH each  PC, PC+4, extended immediate
- Rs1D, Rs2D, RdD  input  REG_ADDR_WIDTH each  source/destination register indices
- Outputs: the E-suffixed counterpart of every D-suffixed input above (RegWriteE … RdE, ValidE), same width, registered.
- BubbleCount  output  CNT_WIDTH  number of flushes since reset, saturating.

Behaviour:
- Clocking and reset: single clock domain, clk; reset is synchronous and active-high on rst. All state updates on the rising edge of clk.
- Per-edge priority: rst > FlushE > StallE > normal capture.
- rst=1:
  - Every E output is 0: all control bits, ResultSrcE=00, ALUControlE=000, all data/index fields 0, ValidE=0.
  - BubbleCount=0.
  - Reset asserted mid-stream discards the in-flight instruction with no partial update.
- FlushE=1 (rst=0):
  - All control outputs forced to 0 (RegWriteE, MemWriteE, JumpE, BranchE = 0, ALUControlE=000, etc.).
  - All data and index outputs forced to 0 (RdE=0, so no spurious forwarding match); ValidE=0.
  - FlushE with StallE also asserted: flush wins.
  - BubbleCount += 1, unless already all-ones, in which case it holds (saturates, no wrap).
- StallE=1 (rst=0, FlushE=0): all E outputs and BubbleCount hold their previous value.
- Normal capture (rst=0, FlushE=0, StallE=0): every E output takes its D input (1-cycle latency); ValidE=ValidD.
- Invalid instruction: ValidD=0 captured normally still propagates its control bits unchanged. The decode stage guarantees zeroed controls in that case; this block does not mask them.
- Outputs come directly from flops; no combinational path from any input to any output.
- No X propagation: after reset every output is a known value regardless of D inputs.
- Approx. 150–200 RTL lines.

Test Plan:
- Reset: drive all D inputs to 1s, hold rst=1 for 2 cycles → every E output 0, ValidE=0, BubbleCount=0. Release rst → next edge captures the D values.
- Pass-through: RegWriteD=1, ALUControlD=001, RD1D=0x0000_1234, RdD=5, ValidD=1 → exactly one edge later RegWriteE=1, ALUControlE=001, RD1E=0x0000_1234, RdE=5, ValidE=1.
- Stall: load instruction A, then StallE=1 for 3 cycles while D inputs change to B → E outputs remain A for all 3 cycles. Deassert StallE → B appears on the next edge.
- Flush: E holds a branch with RdE=7; assert FlushE=1 for one cycle → next edge all controls 0, RdE=0, ValidE=0, BubbleCount increments 0→1.
- Flush+stall together: FlushE=1 and StallE=1 on the same edge → bubble loaded, not a hold; BubbleCount increments.
- Saturation: with CNT_WIDTH=4, apply 20 consecutive flushes → BubbleCount stops at 15 and stays 15.
